// File: rtl/dnn_weight_sequencer.sv
// Weight-load and bring-up sequencer for the dense DNN: streams weight beats,
// releases each layer from reset with its first beat, then counts frames while live.
module dnn_weight_sequencer #(
    parameter int NumLayers               = 2,
    parameter int MaxNumNerves            = 5,
    parameter int M_W_BitSize             = 4,
    parameter int LNI [NumLayers-1:0]     = '{4, 5},
    parameter int FrameCntBits            = 16
) (
    input  logic                                  clk,
    input  logic                                  res_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic                                  w_valid,
    input  logic [MaxNumNerves*M_W_BitSize-1:0]   w_data,
    output logic                                  w_ready,
    output logic [MaxNumNerves*M_W_BitSize-1:0]   out_weights,
    output logic [NumLayers-1:0]                  layer_en,
    output logic                                  fl_res,
    input  logic                                  dnn_done,
    output logic                                  load_done,
    output logic                                  frame_done,
    output logic [FrameCntBits-1:0]               frame_cnt,
    output logic                                  err
);

    localparam int WW    = MaxNumNerves * M_W_BitSize;
    localparam int IdxW  = (NumLayers > 1) ? $clog2(NumLayers) : 1;
    localparam int BeatW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t                  state_r;
    logic [IdxW-1:0]         layer_idx_r;
    logic [BeatW-1:0]        beat_cnt_r;
    logic                    w_ready_r;
    logic [WW-1:0]           out_weights_r;
    logic [NumLayers-1:0]    layer_en_r;
    logic                    fl_res_r;
    logic                    load_done_r;
    logic                    frame_done_r;
    logic [FrameCntBits-1:0] frame_cnt_r;
    logic                    err_r;
    logic                    beat_last_s;
    logic                    layer_last_s;

    // Layer j's beat count lives in LNI[NumLayers-1-j]; returns its last beat index.
    function automatic logic [BeatW-1:0] last_beat(input logic [IdxW-1:0] idx);
        logic [BeatW-1:0] r;
        r = {BeatW{1'b0}};
        for (int j = 0; j < NumLayers; j++) begin
            if (idx == IdxW'(j)) begin
                r = BeatW'(LNI[NumLayers-1-j] - 1);
            end
        end
        return r;
    endfunction

    assign beat_last_s  = (beat_cnt_r == last_beat(layer_idx_r));
    assign layer_last_s = (layer_idx_r == IdxW'(NumLayers - 1));

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r       <= ST_IDLE;
            layer_idx_r   <= {IdxW{1'b0}};
            beat_cnt_r    <= {BeatW{1'b0}};
            w_ready_r     <= 1'b0;
            out_weights_r <= {WW{1'b0}};
            layer_en_r    <= {NumLayers{1'b0}};
            fl_res_r      <= 1'b0;
            load_done_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_cnt_r   <= {FrameCntBits{1'b0}};
            err_r         <= 1'b0;
        end else begin
            out_weights_r <= {WW{1'b0}};
            fl_res_r      <= 1'b0;
            frame_done_r  <= 1'b0;
            if (abort) begin
                state_r     <= ST_IDLE;
                w_ready_r   <= 1'b0;
                layer_en_r  <= {NumLayers{1'b0}};
                load_done_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            state_r     <= ST_LOAD;
                            layer_idx_r <= {IdxW{1'b0}};
                            beat_cnt_r  <= {BeatW{1'b0}};
                            err_r       <= 1'b0;
                            frame_cnt_r <= {FrameCntBits{1'b0}};
                            w_ready_r   <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (w_valid) begin
                            out_weights_r <= w_data;
                            if (beat_cnt_r == {BeatW{1'b0}}) begin
                                layer_en_r[layer_idx_r] <= 1'b1;
                            end
                            if (beat_last_s) begin
                                beat_cnt_r <= {BeatW{1'b0}};
                                if (layer_last_s) begin
                                    state_r     <= ST_RUN;
                                    w_ready_r   <= 1'b0;
                                    load_done_r <= 1'b1;
                                    fl_res_r    <= 1'b1;
                                end else begin
                                    layer_idx_r <= layer_idx_r + IdxW'(1);
                                end
                            end else begin
                                beat_cnt_r <= beat_cnt_r + BeatW'(1);
                            end
                        end else if (beat_cnt_r != {BeatW{1'b0}}) begin
                            // Arrays cannot stall mid-layer: a gap here is fatal to the load.
                            state_r    <= ST_ERR;
                            err_r      <= 1'b1;
                            w_ready_r  <= 1'b0;
                            layer_en_r <= {NumLayers{1'b0}};
                        end
                    end
                    ST_RUN: begin
                        if (dnn_done) begin
                            frame_cnt_r  <= frame_cnt_r + FrameCntBits'(1);
                            frame_done_r <= 1'b1;
                        end
                    end
                    ST_ERR: begin
                        if (start) begin
                            state_r     <= ST_LOAD;
                            layer_idx_r <= {IdxW{1'b0}};
                            beat_cnt_r  <= {BeatW{1'b0}};
                            err_r       <= 1'b0;
                            w_ready_r   <= 1'b1;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        w_ready_r  <= 1'b0;
                        layer_en_r <= {NumLayers{1'b0}};
                    end
                endcase
            end
        end
    end

    assign w_ready     = w_ready_r;
    assign out_weights = out_weights_r;
    assign layer_en    = layer_en_r;
    assign fl_res      = fl_res_r;
    assign load_done   = load_done_r;
    assign frame_done  = frame_done_r;
    assign frame_cnt   = frame_cnt_r;
    assign err         = err_r;

endmodule

// File: tb/tb_dnn_weight_sequencer.sv
// Scoreboard bench for dnn_weight_sequencer: stimulus queues expected beats/frames,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dnn_weight_sequencer;

    localparam int WW = 20;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          w_valid = 1'b0;
    logic          dnn_done = 1'b0;
    logic [WW-1:0] w_data = '0;

    logic          w_ready, fl_res, load_done, frame_done, err;
    logic [WW-1:0] out_weights;
    logic [1:0]    layer_en;
    logic [15:0]   frame_cnt;

    logic          w_ready2, fl_res2, load_done2, frame_done2, err2;
    logic [WW-1:0] out_weights2;
    logic [1:0]    layer_en2;
    logic [1:0]    frame_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW+1:0] beat_q[$];
    logic [15:0]   frame_q[$];
    logic [WW+1:0] mon_beat;
    logic [15:0]   mon_frame;

    dnn_weight_sequencer dut (
        .clk(clk), .res_n(res_n), .start(start), .abort(abort),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .out_weights(out_weights), .layer_en(layer_en), .fl_res(fl_res),
        .dnn_done(dnn_done), .load_done(load_done), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .err(err)
    );

    dnn_weight_sequencer #(.FrameCntBits(2)) dut_w2 (
        .clk(clk), .res_n(res_n), .start(start), .abort(abort),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready2),
        .out_weights(out_weights2), .layer_en(layer_en2), .fl_res(fl_res2),
        .dnn_done(dnn_done), .load_done(load_done2), .frame_done(frame_done2),
        .frame_cnt(frame_cnt2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every nonzero beat and every frame_done pulse must match the next queued entry.
    always @(negedge clk) begin
        if (res_n) begin
            if (out_weights != '0) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_weights), 32'd0);
                end else begin
                    mon_beat = beat_q.pop_front();
                    chk("beat_data", 32'(out_weights), 32'(mon_beat[WW+1:2]));
                    chk("beat_layer_en", 32'(layer_en), 32'(mon_beat[1:0]));
                end
            end
            if (frame_done) begin
                if (frame_q.size() == 0) begin
                    chk("unexpected_frame_done", 32'(frame_cnt), 32'hFFFF_FFFF);
                end else begin
                    mon_frame = frame_q.pop_front();
                    chk("frame_cnt_on_done", 32'(frame_cnt), 32'(mon_frame));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int v, input logic [1:0] en);
        chk("w_ready_on_beat", 32'(w_ready), 32'd1);
        w_valid = 1'b1;
        w_data  = WW'(v);
        beat_q.push_back({WW'(v), en});
        tick();
        w_valid = 1'b0;
        w_data  = '0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send(i, (i <= 4) ? 2'b01 : 2'b11);
        end
    endtask

    task automatic frame(input logic [15:0] exp);
        dnn_done = 1'b1;
        frame_q.push_back(exp);
        tick();
        dnn_done = 1'b0;
        tick();
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_out_weights", 32'(out_weights), 32'd0);
        chk("rst_layer_en", 32'(layer_en), 32'd0);
        chk("rst_w_ready", 32'(w_ready), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_fl_res", 32'(fl_res), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        res_n = 1'b1;
        tick();

        // Contiguous load of beats 1..9
        pulse_start();
        chk("load_w_ready", 32'(w_ready), 32'd1);
        chk("load_layer_en_pre", 32'(layer_en), 32'd0);
        send_range(1, 9);
        chk("run_load_done", 32'(load_done), 32'd1);
        chk("run_fl_res_first", 32'(fl_res), 32'd1);
        chk("run_w_ready", 32'(w_ready), 32'd0);
        chk("run_layer_en", 32'(layer_en), 32'd3);
        tick();
        chk("run_fl_res_second", 32'(fl_res), 32'd0);
        chk("run_load_done_held", 32'(load_done), 32'd1);

        // Frames, with wrap on the 2-bit counter instance
        frame(16'd1);
        frame(16'd2);
        frame(16'd3);
        chk("frame_cnt_3", 32'(frame_cnt), 32'd3);
        chk("frame_cnt2_3", 32'(frame_cnt2), 32'd3);
        frame(16'd4);
        chk("frame_cnt_4", 32'(frame_cnt), 32'd4);
        chk("frame_cnt2_wrap", 32'(frame_cnt2), 32'd0);

        // start is ignored in RUN
        pulse_start();
        chk("run_start_ignored_ready", 32'(w_ready), 32'd0);
        chk("run_start_ignored_done", 32'(load_done), 32'd1);

        // abort together with dnn_done: frame not counted
        abort = 1'b1;
        dnn_done = 1'b1;
        tick();
        abort = 1'b0;
        dnn_done = 1'b0;
        chk("abort_load_done", 32'(load_done), 32'd0);
        chk("abort_layer_en", 32'(layer_en), 32'd0);
        chk("abort_frame_held", 32'(frame_cnt), 32'd4);
        chk("abort_frame_done", 32'(frame_done), 32'd0);
        dnn_done = 1'b1;
        tick();
        dnn_done = 1'b0;
        tick();
        chk("idle_dnn_done_ignored", 32'(frame_cnt), 32'd4);

        // Inter-layer gap is allowed
        pulse_start();
        chk("restart_frame_cnt_clr", 32'(frame_cnt), 32'd0);
        send_range(1, 4);
        tick();
        tick();
        tick();
        chk("gap_err", 32'(err), 32'd0);
        chk("gap_layer_en", 32'(layer_en), 32'd1);
        chk("gap_w_ready", 32'(w_ready), 32'd1);
        send_range(5, 9);
        chk("gap_load_done", 32'(load_done), 32'd1);
        chk("gap_err_after", 32'(err), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Underrun after beat 2, then a clean reload
        pulse_start();
        send_range(1, 2);
        tick();
        chk("underrun_err", 32'(err), 32'd1);
        chk("underrun_layer_en", 32'(layer_en), 32'd0);
        chk("underrun_w_ready", 32'(w_ready), 32'd0);
        chk("underrun_load_done", 32'(load_done), 32'd0);
        pulse_start();
        chk("err_restart_err", 32'(err), 32'd0);
        chk("err_restart_w_ready", 32'(w_ready), 32'd1);
        send_range(1, 9);
        chk("reload_load_done", 32'(load_done), 32'd1);
        chk("reload_err", 32'(err), 32'd0);
        chk("reload_layer_en", 32'(layer_en), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Abort on beat 6: beat dropped
        pulse_start();
        send_range(1, 5);
        abort = 1'b1;
        w_valid = 1'b1;
        w_data = WW'(6);
        tick();
        abort = 1'b0;
        w_valid = 1'b0;
        w_data = '0;
        chk("abort6_out_weights", 32'(out_weights), 32'd0);
        chk("abort6_layer_en", 32'(layer_en), 32'd0);
        chk("abort6_w_ready", 32'(w_ready), 32'd0);
        dnn_done = 1'b1;
        tick();
        dnn_done = 1'b0;
        tick();
        chk("abort6_frame_cnt", 32'(frame_cnt), 32'd0);

        // Async reset mid-RUN
        pulse_start();
        send_range(1, 9);
        frame(16'd1);
        @(posedge clk);
        #3;
        res_n = 1'b0;
        #1;
        chk("async_load_done", 32'(load_done), 32'd0);
        chk("async_layer_en", 32'(layer_en), 32'd0);
        chk("async_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();

        chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
        chk("frame_q_empty", 32'(frame_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
